// File: rtl/rng_state_pkg.sv
// Shared definitions for the RNG state store.
//   state_e   : sequencer states (fill, idle, response pending)
//   SIZE_W    : width of the constant size output
//   in_range  : non-wrapping bounds check of offset+nbytes against the store size
package rng_state_pkg;

  localparam int unsigned SIZE_W = 16;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // The sum is formed one bit wider than the offset so a large offset can
  // never wrap back into the legal window.
  function automatic logic in_range(input logic [31:0] offset,
                                    input logic [3:0]  nbytes,
                                    input int unsigned num_bytes);
    logic [32:0] end_excl;
    end_excl = {1'b0, offset} + {29'd0, nbytes};
    return end_excl <= 33'(num_bytes);
  endfunction

endpackage

// File: rtl/rng_state_mem_if.sv
// Request/response bus of the RNG state store.
//   req_*  : valid/ready request (write flag, first byte offset, byte count, write data)
//   rsp_*  : valid/ready response (little-endian read data, error flag)
//   master : requester side (RNG datapath or host)
//   slave  : state store side
interface rng_state_mem_if #(
  parameter int unsigned OFF_W      = 16,
  parameter int unsigned WORD_BYTES = 8
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [OFF_W-1:0]        req_offset;
  logic [3:0]              req_nbytes;
  logic [8*WORD_BYTES-1:0] req_wdata;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [8*WORD_BYTES-1:0] rsp_rdata;
  logic                    rsp_err;

  modport master (
    output req_valid, req_write, req_offset, req_nbytes, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_offset, req_nbytes, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/rng_state_lane_mask.sv
// Byte-lane enable mask: lane k is enabled when k < nbytes.
//   nbytes : requested byte count (0..15)
//   mask   : WORD_BYTES-bit lane enable, shared by write enables and read zeroing
module rng_state_lane_mask #(
  parameter int unsigned WORD_BYTES = 8
) (
  input  logic [3:0]            nbytes,
  output logic [WORD_BYTES-1:0] mask
);

  always_comb begin
    mask = '0;
    for (int unsigned k = 0; k < WORD_BYTES; k++) begin
      mask[k] = (k < 32'(nbytes));
    end
  end

endmodule

// File: rtl/rng_state_mem.sv
// Byte-addressable RNG state store with bounds checking and a fill sequencer.
//   clk        : clock, rising edge
//   rst        : synchronous active-low reset
//   bus        : request/response bus (slave side)
//   init_req   : start a bulk fill with init_value (wins over a pending request)
//   init_value : fill byte, sampled when the fill is accepted
//   busy       : high while the fill sequence runs
//   size       : constant NUM_BYTES
module rng_state_mem
  import rng_state_pkg::*;
#(
  parameter int unsigned NUM_BYTES  = 32,
  parameter int unsigned WORD_BYTES = 8,
  parameter int unsigned OFF_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  rng_state_mem_if.slave      bus,
  input  logic                init_req,
  input  logic [7:0]          init_value,
  output logic                busy,
  output logic [SIZE_W-1:0]   size
);

  localparam int unsigned PTR_W  = $clog2(NUM_BYTES);
  localparam int unsigned DATA_W = 8 * WORD_BYTES;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [7:0]        fill_q, fill_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [7:0]        mem_q [NUM_BYTES];
  logic [7:0]        mem_d [NUM_BYTES];

  logic [WORD_BYTES-1:0] lane_mask;
  logic                  req_ready;
  logic                  accept;
  logic                  req_zero;
  logic                  req_go;
  logic                  req_err;
  logic [DATA_W-1:0]     rd_data;
  logic [OFF_W:0]        lane_idx;

  rng_state_lane_mask #(
    .WORD_BYTES (WORD_BYTES)
  ) u_lane_mask (
    .nbytes (bus.req_nbytes),
    .mask   (lane_mask)
  );

  // Request classification: zero length is a silent no-op, oversize or
  // out-of-window requests are rejected, everything else touches memory.
  always_comb begin
    req_zero = (bus.req_nbytes == 4'd0);
    req_go   = !req_zero
            && (32'(bus.req_nbytes) <= WORD_BYTES)
            && in_range(32'(bus.req_offset), bus.req_nbytes, NUM_BYTES);
    req_err  = !req_zero && !req_go;
  end

  assign req_ready = ((state_q == ST_IDLE) || ((state_q == ST_RESP) && bus.rsp_ready))
                  && !init_req && rst;
  assign accept    = bus.req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    fill_d      = fill_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    mem_d       = mem_q;
    rd_data     = '0;
    lane_idx    = '0;

    // Lane gather/scatter: lane k maps to byte offset+k. The index is only
    // used when the request passed the bounds check.
    for (int unsigned k = 0; k < WORD_BYTES; k++) begin
      lane_idx = {1'b0, bus.req_offset} + (OFF_W+1)'(k);
      for (int unsigned j = 0; j < NUM_BYTES; j++) begin
        if (req_go && lane_mask[k] && (lane_idx == (OFF_W+1)'(j))) begin
          rd_data[8*k +: 8] = mem_q[j];
          if (accept && bus.req_write) begin
            mem_d[j] = bus.req_wdata[8*k +: 8];
          end
        end
      end
    end

    case (state_q)
      ST_INIT: begin
        mem_d[ptr_q] = fill_q;
        ptr_d        = ptr_q + 1'b1;
        if (ptr_q == PTR_W'(NUM_BYTES - 1)) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end
      end
      ST_IDLE: begin
        if (init_req) begin
          state_d = ST_INIT;
          ptr_d   = '0;
          fill_d  = init_value;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (init_req) begin
            state_d = ST_INIT;
            ptr_d   = '0;
            fill_d  = init_value;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_INIT;
        ptr_d   = '0;
      end
    endcase

    // An accepted request overrides the fall-back to IDLE when the
    // previous response is consumed in the same cycle.
    if (accept) begin
      state_d     = ST_RESP;
      rsp_valid_d = 1'b1;
      rsp_err_d   = req_err;
      rsp_rdata_d = (req_go && !bus.req_write) ? rd_data : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_INIT;
      ptr_q       <= '0;
      fill_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      fill_q      <= fill_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Memory contents survive reset; the fill sequence clears them afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= mem_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign busy          = (state_q == ST_INIT);
  assign size          = SIZE_W'(NUM_BYTES);

endmodule

// File: tb/tb_rng_state_mem.sv
module tb_rng_state_mem;

  localparam int unsigned NB = 32;
  localparam int unsigned WB = 8;

  logic        clk;
  logic        rst;
  logic        init_req;
  logic [7:0]  init_value;
  logic        busy;
  logic [15:0] size;

  rng_state_mem_if #(.OFF_W(16), .WORD_BYTES(WB)) bus ();

  rng_state_mem #(
    .NUM_BYTES  (NB),
    .WORD_BYTES (WB),
    .OFF_W      (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .init_req   (init_req),
    .init_value (init_value),
    .busy       (busy),
    .size       (size)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] model [NB];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_fill(input logic [7:0] v);
    for (int i = 0; i < NB; i++) model[i] = v;
  endtask

  // Reference behaviour straight from the access rules.
  task automatic model_req(input bit wr, input logic [15:0] off, input logic [3:0] n,
                           input logic [63:0] wd, output logic err, output logic [63:0] rd);
    int unsigned o, nn;
    o = off; nn = n; err = 1'b0; rd = '0;
    if (nn == 0) begin
      err = 1'b0;
    end else if (nn > WB || o + nn > NB) begin
      err = 1'b1;
    end else begin
      for (int unsigned k = 0; k < nn; k++) begin
        if (wr) model[o+k] = wd[8*k +: 8];
        else    rd[8*k +: 8] = model[o+k];
      end
    end
  endtask

  task automatic drive(input bit wr, input logic [15:0] off, input logic [3:0] n,
                       input logic [63:0] wd);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_offset = off;
    bus.req_nbytes = n;
    bus.req_wdata  = wd;
  endtask

  task automatic do_req(input string tag, input bit wr, input logic [15:0] off,
                        input logic [3:0] n, input logic [63:0] wd);
    int cnt;
    logic e;
    logic [63:0] r;
    drive(wr, off, n, wd);
    #1;
    cnt = 0;
    while (!bus.req_ready && cnt < 50) begin
      tick;
      cnt++;
    end
    if (cnt >= 50) chk({tag, "_ready_timeout"}, 64'(bus.req_ready), 64'd1);
    model_req(wr, off, n, wd, e, r);
    tick;
    bus.req_valid = 1'b0;
    chk({tag, "_valid"}, 64'(bus.rsp_valid), 64'd1);
    chk({tag, "_err"},   64'(bus.rsp_err),   64'(e));
    chk({tag, "_rdata"}, bus.rsp_rdata,      r);
    tick;
  endtask

  task automatic count_busy(input string tag);
    int cnt;
    bit saw_ready;
    cnt = 0;
    saw_ready = 1'b0;
    while (busy && cnt < 100) begin
      if (bus.req_ready) saw_ready = 1'b1;
      cnt++;
      tick;
    end
    chk({tag, "_busy_cycles"}, 64'(cnt), 64'd32);
    chk({tag, "_ready_low"},   64'(saw_ready), 64'd0);
  endtask

  initial begin
    logic e1, e2, e3;
    logic [63:0] r1, r2, r3, wd;
    logic [15:0] off;
    logic [3:0]  n;
    bit wr;

    rst = 1'b0;
    init_req = 1'b0;
    init_value = 8'h00;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_offset = '0;
    bus.req_nbytes = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;

    // reset state
    tick; tick; tick;
    chk("rst_busy",      64'(busy), 64'd1);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_err",   64'(bus.rsp_err), 64'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("size",          64'(size), 64'd32);
    rst = 1'b1;
    count_busy("init0");
    model_fill(8'h00);

    do_req("rd0", 1'b0, 16'd0, 4'd8, '0);
    do_req("wr3", 1'b1, 16'd3, 4'd4, 64'hDEADBEEF);
    do_req("rd3", 1'b0, 16'd3, 4'd4, '0);
    chk("rd3_direct", bus.rsp_rdata, 64'hDEADBEEF);
    do_req("rd2", 1'b0, 16'd2, 4'd2, '0);
    chk("rd2_direct", bus.rsp_rdata, 64'hEF00);

    // bounds and size checks
    do_req("rd28n5",  1'b0, 16'd28, 4'd5, '0);
    do_req("wr30n9",  1'b1, 16'd30, 4'd9, 64'h1122334455667788);
    do_req("rd30n2",  1'b0, 16'd30, 4'd2, '0);
    do_req("n0",      1'b0, 16'd5,  4'd0, '0);
    do_req("wrn0",    1'b1, 16'd3,  4'd0, 64'hFF);
    do_req("rd24n8",  1'b0, 16'd24, 4'd8, '0);
    do_req("rd32n1",  1'b0, 16'd32, 4'd1, '0);
    do_req("rdwrap",  1'b0, 16'hFFFF, 4'd2, '0);
    do_req("wr31n1",  1'b1, 16'd31, 4'd1, 64'h5A);
    do_req("rd31n1",  1'b0, 16'd31, 4'd1, '0);

    // init_req wins over a simultaneous request
    init_value = 8'hA5;
    init_req = 1'b1;
    drive(1'b0, 16'd0, 4'd8, '0);
    #1;
    chk("init_blocks_ready", 64'(bus.req_ready), 64'd0);
    tick;
    init_req = 1'b0;
    init_value = 8'h00;
    count_busy("initA5");
    bus.req_valid = 1'b0;
    model_fill(8'hA5);
    do_req("rdA5", 1'b0, 16'd24, 4'd8, '0);
    chk("rdA5_direct", bus.rsp_rdata, 64'hA5A5A5A5A5A5A5A5);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      wr  = $urandom_range(0, 1) == 1;
      off = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF))
                                        : 16'($urandom_range(0, 34));
      n   = 4'($urandom_range(0, 10));
      wd  = {$urandom, $urandom};
      do_req("rand", wr, off, n, wd);
    end

    // response stall then back-to-back
    bus.rsp_ready = 1'b0;
    drive(1'b0, 16'd0, 4'd8, '0);
    #1;
    model_req(1'b0, 16'd0, 4'd8, '0, e1, r1);
    tick;
    drive(1'b0, 16'd8, 4'd8, '0);
    model_req(1'b0, 16'd8, 4'd8, '0, e2, r2);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 64'(bus.rsp_valid), 64'd1);
      chk("stall_rdata", bus.rsp_rdata, r1);
      chk("stall_ready", 64'(bus.req_ready), 64'd0);
      tick;
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("unstall_ready", 64'(bus.req_ready), 64'd1);
    tick;
    chk("b2b1_valid", 64'(bus.rsp_valid), 64'd1);
    chk("b2b1_rdata", bus.rsp_rdata, r2);
    wd = {$urandom, $urandom};
    drive(1'b1, 16'd16, 4'd4, wd);
    model_req(1'b1, 16'd16, 4'd4, wd, e3, r3);
    tick;
    chk("b2b2_valid", 64'(bus.rsp_valid), 64'd1);
    chk("b2b2_err",   64'(bus.rsp_err), 64'(e3));
    chk("b2b2_rdata", bus.rsp_rdata, r3);
    bus.req_valid = 1'b0;
    tick;
    chk("b2b_done", 64'(bus.rsp_valid), 64'd0);
    do_req("rd16", 1'b0, 16'd16, 4'd4, '0);

    // reset in the middle of a fill
    init_value = 8'h3C;
    init_req = 1'b1;
    tick;
    init_req = 1'b0;
    repeat (10) tick;
    chk("midinit_busy", 64'(busy), 64'd1);
    rst = 1'b0;
    tick;
    chk("midinit_rst_busy",  64'(busy), 64'd1);
    chk("midinit_rst_valid", 64'(bus.rsp_valid), 64'd0);
    rst = 1'b1;
    count_busy("midinit");
    model_fill(8'h00);
    do_req("midinit_rd", 1'b0, 16'd0, 4'd8, '0);
    do_req("midinit_wr", 1'b1, 16'd16, 4'd4, 64'h0BADF00D);

    // reset while a response is pending
    bus.rsp_ready = 1'b0;
    drive(1'b0, 16'd16, 4'd4, '0);
    tick;
    bus.req_valid = 1'b0;
    chk("midresp_valid", 64'(bus.rsp_valid), 64'd1);
    rst = 1'b0;
    tick;
    chk("midresp_rst_valid", 64'(bus.rsp_valid), 64'd0);
    chk("midresp_rst_err",   64'(bus.rsp_err), 64'd0);
    chk("midresp_rst_rdata", bus.rsp_rdata, 64'd0);
    chk("midresp_rst_busy",  64'(busy), 64'd1);
    rst = 1'b1;
    bus.rsp_ready = 1'b1;
    count_busy("midresp");
    model_fill(8'h00);
    do_req("midresp_rd", 1'b0, 16'd16, 4'd4, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
